score_keeper: RTL and testbench

- Upstream stage of the LED blink-speed divider. Debounces the player's pushbutton and judges each press against the blink signal (`sclk`) that the divider produces.
- Maintains the 4-bit score that sets the divider's blink rate. A press while the LED is on is a hit; a press while it is off is a miss.
- Drives the LED, which is solid on after a win.

---
 rtl/score_keeper.sv | 148 ++++++++++++++
 tb/tb_score_keeper.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// ============================================================================
// Module   : score_keeper
// Brief    : Debounces the player button, judges presses against the blink
//            window (sclk) and keeps the 4-bit score that drives the divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

module score_keeper #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_SCORE       = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       sclk,
    output logic [3:0] score,
    output logic       led,
    output logic       hit,
    output logic       miss,
    output logic       win
);

    localparam int              CNT_W     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]      SCORE_MAX = 4'(MAX_SCORE);
    localparam logic [3:0]      SCORE_PRE = 4'(MAX_SCORE - 1);

    typedef enum logic [0:0] {
        S_PLAY = 1'b0,
        S_WIN  = 1'b1
    } state_t;

    logic             r_sync0;
    logic             r_sync1;
    logic             r_db;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_press;
    logic             r_sclk_prev;
    logic             r_armed;
    logic [3:0]       r_score;
    logic             r_led;
    logic             r_hit;
    logic             r_miss;
    state_t           r_state;

    state_t           w_state_nxt;
    logic [3:0]       w_score_nxt;
    logic             w_armed_nxt;
    logic             w_hit_nxt;
    logic             w_miss_nxt;
    logic             w_sclk_rise;

    // Button path: 2-flop synchronizer, then a stable-run debouncer whose
    // accepted 0->1 transition is flagged for exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync0  <= 1'b0;
            r_sync1  <= 1'b0;
            r_db     <= 1'b0;
            r_db_cnt <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync0 <= btn;
            r_sync1 <= r_sync0;
            r_press <= 1'b0;
            if (r_sync1 == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == CNT_LAST) begin
                r_db     <= r_sync1;
                r_db_cnt <= '0;
                r_press  <= r_sync1;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_sclk_rise = sclk & ~r_sclk_prev;

    always_comb begin
        w_state_nxt = r_state;
        w_score_nxt = r_score;
        w_armed_nxt = r_armed | w_sclk_rise;
        w_hit_nxt   = 1'b0;
        w_miss_nxt  = 1'b0;
        case (r_state)
            S_PLAY: begin
                if (r_press) begin
                    // A rising edge in the press cycle re-arms before judging.
                    if (sclk && (r_armed || w_sclk_rise)) begin
                        w_hit_nxt   = 1'b1;
                        w_score_nxt = r_score + 4'd1;
                        w_armed_nxt = 1'b0;
                        if (r_score == SCORE_PRE) begin
                            w_state_nxt = S_WIN;
                        end
                    end else begin
                        w_miss_nxt = 1'b1;
                        if (r_score != 4'd0) begin
                            w_score_nxt = r_score - 4'd1;
                        end
                    end
                end
            end
            S_WIN: begin
                w_score_nxt = SCORE_MAX;
                if (r_press) begin
                    w_state_nxt = S_PLAY;
                    w_score_nxt = 4'd0;
                    w_armed_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_PLAY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_PLAY;
            r_score     <= 4'd0;
            r_armed     <= 1'b1;
            r_sclk_prev <= 1'b0;
            r_led       <= 1'b0;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_score     <= w_score_nxt;
            r_armed     <= w_armed_nxt;
            r_sclk_prev <= sclk;
            r_led       <= (w_state_nxt == S_WIN) | sclk;
            r_hit       <= w_hit_nxt;
            r_miss      <= w_miss_nxt;
        end
    end

    assign score = r_score;
    assign led   = r_led;
    assign hit   = r_hit;
    assign miss  = r_miss;
    assign win   = (r_state == S_WIN);

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
// Module   : tb_score_keeper
// Brief    : Directed plus random stimulus for score_keeper, two score limits,
//            compared each cycle against a rule-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_score_keeper;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn = 1'b0;
    logic       sclk = 1'b0;
    logic [3:0] score_a, score_b;
    logic       led_a, hit_a, miss_a, win_a;
    logic       led_b, hit_b, miss_b, win_b;

    int checks = 0;
    int errors = 0;

    score_keeper #(.DEBOUNCE_CYCLES(DEB), .MAX_SCORE(3)) dut_a (
        .clk(clk), .reset(reset), .btn(btn), .sclk(sclk),
        .score(score_a), .led(led_a), .hit(hit_a), .miss(miss_a), .win(win_a)
    );

    score_keeper #(.DEBOUNCE_CYCLES(DEB), .MAX_SCORE(10)) dut_b (
        .clk(clk), .reset(reset), .btn(btn), .sclk(sclk),
        .score(score_b), .led(led_b), .hit(hit_b), .miss(miss_b), .win(win_b)
    );

    always #5 clk = ~clk;

    // Reference model state: btn history, run length of disagreement, game.
    bit m_s0, m_s1, m_db, m_press, m_prev;
    int m_run;
    int m_score[2];
    bit m_win[2], m_led[2], m_hit[2], m_miss[2], m_armed[2];
    int maxv[2] = '{3, 10};
    int n_hit_a = 0, n_miss_a = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_update();
        bit rise;
        bit p;
        if (reset) begin
            m_s0 = 0; m_s1 = 0; m_db = 0; m_press = 0; m_prev = 0; m_run = 0;
            for (int k = 0; k < 2; k++) begin
                m_score[k] = 0; m_win[k] = 0; m_led[k] = 0;
                m_hit[k] = 0; m_miss[k] = 0; m_armed[k] = 1;
            end
            return;
        end
        rise = sclk && !m_prev;
        p    = m_press;
        for (int k = 0; k < 2; k++) begin
            m_hit[k]  = 0;
            m_miss[k] = 0;
            if (m_win[k]) begin
                if (p) begin
                    m_win[k] = 0; m_score[k] = 0; m_armed[k] = 1;
                end else if (rise) begin
                    m_armed[k] = 1;
                end
            end else if (p) begin
                if (sclk && (m_armed[k] || rise)) begin
                    m_hit[k] = 1;
                    m_score[k]++;
                    m_armed[k] = 0;
                    if (m_score[k] == maxv[k]) m_win[k] = 1;
                end else begin
                    m_miss[k] = 1;
                    if (m_score[k] > 0) m_score[k]--;
                end
            end else if (rise) begin
                m_armed[k] = 1;
            end
            m_led[k] = m_win[k] ? 1'b1 : sclk;
        end
        // Debounced value follows the synchronized button after DEB
        // consecutive cycles of disagreement.
        m_press = 0;
        if (m_s1 != m_db) begin
            m_run++;
            if (m_run == DEB) begin
                m_db = m_s1; m_run = 0; m_press = m_db;
            end
        end else begin
            m_run = 0;
        end
        m_s1 = m_s0;
        m_s0 = btn;
        m_prev = sclk;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("score_a", 32'(score_a), 32'(m_score[0]));
        chk("led_a",   32'(led_a),   32'(m_led[0]));
        chk("hit_a",   32'(hit_a),   32'(m_hit[0]));
        chk("miss_a",  32'(miss_a),  32'(m_miss[0]));
        chk("win_a",   32'(win_a),   32'(m_win[0]));
        chk("score_b", 32'(score_b), 32'(m_score[1]));
        chk("led_b",   32'(led_b),   32'(m_led[1]));
        chk("hit_b",   32'(hit_b),   32'(m_hit[1]));
        chk("miss_b",  32'(miss_b),  32'(m_miss[1]));
        chk("win_b",   32'(win_b),   32'(m_win[1]));
        chk("hit_miss_excl_a", 32'(hit_a & miss_a), 32'd0);
        chk("hit_miss_excl_b", 32'(hit_b & miss_b), 32'd0);
        if (hit_a === 1'b1) n_hit_a++;
        if (miss_a === 1'b1) n_miss_a++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int sclk_left;
        int btn_left;

        // Reset held with the button down; press lands 6 cycles after release.
        reset = 1'b1; btn = 1'b1; sclk = 1'b0;
        steps(2);
        chk("reset_score", 32'(score_a), 32'd0);
        chk("reset_win",   32'(win_a),   32'd0);
        reset = 1'b0; sclk = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("early_hit", 32'(hit_a), 32'd0);
        end
        step();
        chk("reset_hold_hit", 32'(hit_a), 32'd1);
        chk("reset_hold_score", 32'(score_a), 32'd1);

        // Second press in the same on-window is a miss.
        btn = 1'b0; steps(8);
        n_miss_a = 0;
        btn = 1'b1; steps(8);
        chk("repeat_miss_cnt", 32'(n_miss_a), 32'd1);
        chk("repeat_score", 32'(score_a), 32'd0);
        btn = 1'b0; steps(8);

        // Bounce rejection.
        n_hit_a = 0; n_miss_a = 0;
        for (int i = 0; i < 40; i++) begin
            btn = ((i / 2) % 2) == 0;
            step();
        end
        btn = 1'b0; steps(10);
        chk("bounce_events", 32'(n_hit_a + n_miss_a), 32'd0);

        // Miss saturation with LED off.
        sclk = 1'b0; n_miss_a = 0;
        for (int i = 0; i < 2; i++) begin
            btn = 1'b1; steps(8);
            btn = 1'b0; steps(8);
        end
        chk("sat_miss_cnt", 32'(n_miss_a), 32'd2);
        chk("sat_score", 32'(score_a), 32'd0);

        // One hit per window: A wins at 3, B at 10, each exits on the next press.
        for (int w = 1; w <= 11; w++) begin
            sclk = 1'b1; steps(2);
            btn = 1'b1;  steps(8);
            btn = 1'b0;  steps(8);
            sclk = 1'b0; steps(4);
            if (w == 3) begin
                chk("win3_score", 32'(score_a), 32'd3);
                chk("win3_win", 32'(win_a), 32'd1);
                chk("win3_led", 32'(led_a), 32'd1);
            end
            if (w == 4) begin
                chk("restart_score", 32'(score_a), 32'd0);
                chk("restart_win", 32'(win_a), 32'd0);
            end
            if (w == 10) begin
                chk("win10_score", 32'(score_b), 32'd10);
                chk("win10_win", 32'(win_b), 32'd1);
            end
        end
        chk("b_restart_score", 32'(score_b), 32'd0);

        // Press event coincides with the sclk rising edge after a prior hit.
        reset = 1'b1; btn = 1'b0; steps(2);
        reset = 1'b0;
        sclk = 1'b1; steps(2);
        btn = 1'b1;  steps(8);
        btn = 1'b0;  steps(8);
        sclk = 1'b0; steps(4);
        btn = 1'b1;  steps(6);
        sclk = 1'b1; step();
        chk("coincide_hit", 32'(hit_a), 32'd1);
        chk("coincide_score", 32'(score_a), 32'd2);
        btn = 1'b0; steps(8);

        // Random blink windows, button holds (glitches and real presses), rare resets.
        sclk_left = 0; btn_left = 0;
        for (int i = 0; i < 2500; i++) begin
            if (sclk_left == 0) begin
                sclk = ~sclk;
                sclk_left = int'($urandom_range(3, 20));
            end else begin
                sclk_left--;
            end
            if (btn_left == 0) begin
                btn = ~btn;
                btn_left = int'($urandom_range(1, 12));
            end else begin
                btn_left--;
            end
            reset = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
